// File: rtl/om_buf_writer_pkg.sv
// Shared types and defaults for the OM receiver sample-buffer front end.
package om_rx_pkg;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 8;
  localparam int CW_DEF  = 16;
  localparam int BLK_LEN = 2 ** AW_DEF;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_e;

endpackage

// File: rtl/om_buf_writer_if.sv
// Sample stream, RAM write port and bank handshake of the I/Q buffer writer.
interface om_buf_writer_if
  import om_rx_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
);

  logic          s_valid;
  logic          s_sof;
  logic [DW-1:0] s_i;
  logic [DW-1:0] s_q;
  logic          we;
  logic [AW:0]   addr_a;
  logic [DW-1:0] din_i;
  logic [DW-1:0] din_q;
  logic          blk_valid;
  logic          blk_bank;
  logic          blk_ack;
  logic          ovf;
  logic [CW-1:0] drop_cnt;

  modport master (
    input  s_valid, s_sof, s_i, s_q, blk_ack,
    output we, addr_a, din_i, din_q, blk_valid, blk_bank, ovf, drop_cnt
  );

  modport slave (
    output s_valid, s_sof, s_i, s_q, blk_ack,
    input  we, addr_a, din_i, din_q, blk_valid, blk_bank, ovf, drop_cnt
  );

endinterface

// File: rtl/om_buf_writer_bank_arb.sv
// Ping-pong bank ownership: per-bank state, oldest-full pointer and the
// blk_valid/blk_bank offer to the reader with ack release.
module om_bank_arb
  import om_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_bank,
  input  logic       wr_last,
  input  logic       blk_ack,
  output logic [1:0] bank_free,
  output logic [1:0] bank_release,
  output logic       blk_valid,
  output logic       blk_bank
);

  bank_state_e bank_q [2];
  logic        oldest_q;
  logic        valid_q;
  logic        rel;
  logic        still_full;

  assign rel = blk_ack & valid_q;

  always_comb begin
    bank_free    = '0;
    bank_release = '0;
    for (int b = 0; b < 2; b++) begin
      bank_free[b]    = (bank_q[b] == BANK_FREE);
      bank_release[b] = rel && (oldest_q == 1'(b));
    end
  end

  // A bank completing on the same edge as an ack keeps the offer alive
  // so blk_valid does not blink low between the two banks.
  assign still_full = ((bank_q[0] == BANK_FULL) && !bank_release[0])
                   || ((bank_q[1] == BANK_FULL) && !bank_release[1])
                   || (rel && wr_en && wr_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) bank_q[b] <= BANK_FREE;
      oldest_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (bank_release[b]) bank_q[b] <= BANK_FREE;
        if (wr_en && (wr_bank == 1'(b)))
          bank_q[b] <= wr_last ? BANK_FULL : BANK_FILLING;
      end
      if (rel) oldest_q <= ~oldest_q;
      valid_q <= still_full;
    end
  end

  assign blk_valid = valid_q;
  assign blk_bank  = oldest_q;

endmodule

// File: rtl/om_buf_writer.sv
// Captures the oversampled I/Q stream into two ping-pong RAM banks and
// hands completed banks to the reader; drops and counts samples when blocked.
module om_buf_writer
  import om_rx_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  om_buf_writer_if.master bus
);

  wr_state_e     state_q, state_d;
  logic          fill_q, fill_d;
  logic [AW-1:0] idx_q, idx_d, wr_idx;
  logic          wr_en, wr_last, drop, other_ready;
  logic [1:0]    bank_free, bank_release;
  logic          blk_valid, blk_bank;

  logic          we_r;
  logic [AW:0]   addr_r;
  logic [DW-1:0] wdat_i, wdat_q;
  logic          ovf_r;
  logic [CW-1:0] drop_r;

  om_bank_arb u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_bank      (fill_q),
    .wr_last      (wr_last),
    .blk_ack      (bus.blk_ack),
    .bank_free    (bank_free),
    .bank_release (bank_release),
    .blk_valid    (blk_valid),
    .blk_bank     (blk_bank)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WR_FILL;
      fill_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
    end
  end

  // The other bank counts as available if it is freed on this very edge.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    wr_en       = 1'b0;
    wr_idx      = idx_q;
    wr_last     = 1'b0;
    drop        = 1'b0;
    other_ready = bank_free[~fill_q] | bank_release[~fill_q];

    case (state_q)
      WR_FILL: begin
        if (bus.s_valid) begin
          wr_en = 1'b1;
          if (bus.s_sof) wr_idx = '0;
        end
      end
      WR_WAIT: begin
        if (bank_free[fill_q]) begin
          state_d = WR_FILL;
          idx_d   = '0;
          wr_idx  = '0;
          wr_en   = bus.s_valid;
        end else begin
          drop = bus.s_valid;
        end
      end
    endcase

    if (wr_en) begin
      wr_last = (wr_idx == '1);
      if (wr_last) begin
        fill_d  = ~fill_q;
        idx_d   = '0;
        state_d = other_ready ? WR_FILL : WR_WAIT;
      end else begin
        idx_d = wr_idx + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r   <= 1'b0;
      addr_r <= '0;
      wdat_i <= '0;
      wdat_q <= '0;
      ovf_r  <= 1'b0;
      drop_r <= '0;
    end else begin
      we_r <= wr_en;
      if (wr_en) begin
        addr_r <= {fill_q, wr_idx};
        wdat_i <= bus.s_i;
        wdat_q <= bus.s_q;
      end
      if (drop) begin
        ovf_r <= 1'b1;
        if (drop_r != '1) drop_r <= drop_r + CW'(1);
      end
    end
  end

  assign bus.we        = we_r;
  assign bus.addr_a    = addr_r;
  assign bus.din_i     = wdat_i;
  assign bus.din_q     = wdat_q;
  assign bus.blk_valid = blk_valid;
  assign bus.blk_bank  = blk_bank;
  assign bus.ovf       = ovf_r;
  assign bus.drop_cnt  = drop_r;

endmodule

// File: tb/tb_om_buf_writer.sv
// Scoreboard bench for om_buf_writer with 8-sample banks (AW=3).
module tb_om_buf_writer;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  om_buf_writer_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  om_buf_writer #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [AW:0]   addr;
    logic [DW-1:0] di;
    logic [DW-1:0] dq;
  } wr_t;

  wr_t expQ[$];
  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every RAM write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (bus.we === 1'b1) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h, expected no write", bus.addr_a);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", 32'(bus.addr_a), 32'(e.addr));
        checkOutput("wr_din_i", 32'(bus.din_i), 32'(e.di));
        checkOutput("wr_din_q", 32'(bus.din_q), 32'(e.dq));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic sof, input logic [DW-1:0] i,
                               input logic [DW-1:0] q, input logic ack,
                               input logic expWr, input logic [AW:0] expAddr);
    step();
    bus.s_valid = v;
    bus.s_sof   = sof;
    bus.s_i     = i;
    bus.s_q     = q;
    bus.blk_ack = ack;
    if (expWr) expQ.push_back('{addr: expAddr, di: i, dq: q});
  endtask

  task automatic sendSample(input int n, input int addr, input logic sof = 1'b0,
                            input logic ack = 1'b0);
    applyStimulus(1'b1, sof, DW'(n), DW'(-n), ack, 1'b1, (AW+1)'(addr));
  endtask

  task automatic dropSample(input int n);
    applyStimulus(1'b1, 1'b0, DW'(n), DW'(-n), 1'b0, 1'b0, '0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic ackPulse();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_we"}, 32'(bus.we), 32'(0));
    checkOutput({tag, "_addr"}, 32'(bus.addr_a), 32'(0));
    checkOutput({tag, "_din_i"}, 32'(bus.din_i), 32'(0));
    checkOutput({tag, "_din_q"}, 32'(bus.din_q), 32'(0));
    checkOutput({tag, "_blk_valid"}, 32'(bus.blk_valid), 32'(0));
    checkOutput({tag, "_blk_bank"}, 32'(bus.blk_bank), 32'(0));
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(0));
    checkOutput({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_i     = '0;
    bus.s_q     = '0;
    bus.blk_ack = 1'b0;
    #3;
    checkReset("por");
    step();
    rst_n = 1'b1;

    // Continuous stream into bank 0, then spill into bank 1.
    for (int n = 0; n < 8; n++) sendSample(n, n);
    sendSample(8, 8);
    checkOutput("blk_valid_on_last_write", 32'(bus.blk_valid), 32'(0));
    sendSample(9, 9);
    checkOutput("blk_valid_after_last_write", 32'(bus.blk_valid), 32'(1));
    checkOutput("blk_bank_first", 32'(bus.blk_bank), 32'(0));

    // No acks: bank 1 fills, the remaining four samples are dropped.
    for (int n = 10; n < 16; n++) sendSample(n, n);
    for (int n = 16; n < 20; n++) dropSample(n);
    idle();
    checkOutput("drop_cnt_wait", 32'(bus.drop_cnt), 32'(4));
    checkOutput("ovf_wait", 32'(bus.ovf), 32'(1));
    checkOutput("blk_valid_wait", 32'(bus.blk_valid), 32'(1));
    checkOutput("blk_bank_wait", 32'(bus.blk_bank), 32'(0));

    // Ack bank 0: offer moves to bank 1, writing resumes at addr 0.
    ackPulse();
    idle();
    checkOutput("blk_valid_after_ack0", 32'(bus.blk_valid), 32'(1));
    checkOutput("blk_bank_after_ack0", 32'(bus.blk_bank), 32'(1));
    sendSample(100, 0);
    ackPulse();
    idle();
    checkOutput("blk_valid_after_ack1", 32'(bus.blk_valid), 32'(0));

    // Block-align marker at index 5 restarts the bank at index 0.
    for (int n = 1; n < 5; n++) sendSample(200 + n, n);
    sendSample(205, 0, 1'b1);
    sendSample(206, 1);
    idle();
    checkOutput("drop_cnt_after_sof", 32'(bus.drop_cnt), 32'(4));
    checkOutput("blk_valid_partial", 32'(bus.blk_valid), 32'(0));
    for (int n = 2; n < 8; n++) sendSample(210 + n, n);
    idle();
    idle();
    checkOutput("blk_valid_after_sof_fill", 32'(bus.blk_valid), 32'(1));
    checkOutput("blk_bank_after_sof_fill", 32'(bus.blk_bank), 32'(0));

    // Ack of bank 0 coinciding with bank 1 completion.
    for (int n = 0; n < 7; n++) sendSample(300 + n, 8 + n);
    sendSample(307, 15, 1'b0, 1'b1);
    idle();
    checkOutput("blk_valid_ack_and_done", 32'(bus.blk_valid), 32'(1));
    checkOutput("blk_bank_ack_and_done", 32'(bus.blk_bank), 32'(1));
    sendSample(400, 0);
    idle();
    checkOutput("drop_cnt_ack_and_done", 32'(bus.drop_cnt), 32'(4));

    // Asynchronous reset in the middle of a fill.
    sendSample(401, 1);
    sendSample(402, 2);
    idle();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("rst_fill");
    step();
    rst_n = 1'b1;
    sendSample(500, 0);

    // Asynchronous reset while waiting for a free bank.
    for (int n = 1; n < 8; n++) sendSample(500 + n, n);
    for (int n = 0; n < 8; n++) sendSample(600 + n, 8 + n);
    dropSample(650);
    dropSample(651);
    idle();
    checkOutput("drop_cnt_pre_rst", 32'(bus.drop_cnt), 32'(2));
    checkOutput("ovf_pre_rst", 32'(bus.ovf), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("rst_wait");
    step();
    rst_n = 1'b1;
    sendSample(700, 0);
    idle();
    idle();
    idle();

    checkOutput("pending_writes", 32'(expQ.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
